// File: rtl/reg_pkg.sv
// Shared constants and types for the register-file write-port controller.
// Requester ids double as the round-robin priority pointer.
package reg_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned CNT_W  = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  typedef enum logic {
    REQ_A,
    REQ_B
  } req_e;

  function automatic req_e other_req(input req_e r);
    return (r == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: readies from the other side's valid and the
// priority pointer, plus the next pointer value after a grant.
module rr_arb2
  import reg_pkg::*;
(
  input  logic en_i,
  input  logic a_valid_i,
  input  logic b_valid_i,
  input  req_e prio_i,
  output logic a_ready_o,
  output logic b_ready_o,
  output logic a_gnt_o,
  output logic b_gnt_o,
  output req_e prio_o
);

  always_comb begin
    // A side may only lose when B is competing and B holds priority, and vice versa,
    // so at most one grant is ever produced.
    a_ready_o = en_i & (~b_valid_i | (prio_i == REQ_A));
    b_ready_o = en_i & (~a_valid_i | (prio_i == REQ_B));
    a_gnt_o   = a_valid_i & a_ready_o;
    b_gnt_o   = b_valid_i & b_ready_o;

    prio_o = prio_i;
    if (a_gnt_o) begin
      prio_o = other_req(REQ_A);
    end else if (b_gnt_o) begin
      prio_o = other_req(REQ_B);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller: zero-fill sweep after reset / on request,
// then round-robin sharing of the single write port between requesters A and B.
module regfile_wb_arbiter
  import reg_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_req,
  output logic              busy,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              writereg,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] writedata
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_e              prio_q, prio_d;
  logic              writereg_q, writereg_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;

  logic arb_en;
  logic a_gnt, b_gnt;
  req_e arb_prio;

  // A clear request in RUN pre-empts both requesters in the same cycle.
  assign arb_en = (state_q == RUN) & ~clear_req;

  rr_arb2 u_arb (
    .en_i      (arb_en),
    .a_valid_i (a_valid),
    .b_valid_i (b_valid),
    .prio_i    (prio_q),
    .a_ready_o (a_ready),
    .b_ready_o (b_ready),
    .a_gnt_o   (a_gnt),
    .b_gnt_o   (b_gnt),
    .prio_o    (arb_prio)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    writereg_d  = 1'b0;
    rd_d        = rd_q;
    writedata_d = writedata_q;

    unique case (state_q)
      CLEAR: begin
        writereg_d  = 1'b1;
        rd_d        = ADDR_W'(cnt_q);
        writedata_d = '0;
        if (cnt_q == CNT_W'(NREGS - 1)) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (a_gnt) begin
          // x0 writes complete the handshake but never reach the file.
          writereg_d  = (a_rd != '0);
          rd_d        = a_rd;
          writedata_d = a_data;
          prio_d      = arb_prio;
        end else if (b_gnt) begin
          writereg_d  = (b_rd != '0);
          rd_d        = b_rd;
          writedata_d = b_data;
          prio_d      = arb_prio;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      prio_q      <= REQ_A;
      writereg_q  <= 1'b0;
      rd_q        <= '0;
      writedata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      writereg_q  <= writereg_d;
      rd_q        <= rd_d;
      writedata_q <= writedata_d;
    end
  end

  assign busy      = (state_q == CLEAR);
  assign writereg  = writereg_q;
  assign rd        = rd_q;
  assign writedata = writedata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: sweep timing, grants, x0 writes,
// clear pre-emption and reset during a sweep.
module tb_regfile_wb_arbiter;

  logic        clock;
  logic        reset;
  logic        clear_req;
  logic        busy;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        writereg;
  logic [4:0]  rd;
  logic [31:0] writedata;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .clear_req (clear_req),
    .busy      (busy),
    .a_valid   (a_valid),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .writereg  (writereg),
    .rd        (rd),
    .writedata (writedata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Entered in cycle 0 (first cycle of CLEAR); leaves at the negedge of cycle 33.
  task automatic check_sweep(input string tag);
    for (int c = 0; c <= 33; c++) begin
      @(negedge clock);
      check_eq($sformatf("%s_busy%0d", tag, c), 32'(busy), 32'(c <= 31));
      if (c == 0 || c == 33) begin
        check_eq($sformatf("%s_we%0d", tag, c), 32'(writereg), 32'd0);
      end else begin
        check_eq($sformatf("%s_we%0d", tag, c), 32'(writereg), 32'd1);
        check_eq($sformatf("%s_rd%0d", tag, c), 32'(rd), 32'(c - 1));
        check_eq($sformatf("%s_wd%0d", tag, c), writedata, 32'd0);
      end
      if (c < 33) next_cycle();
    end
  endtask

  int exp_rd [4] = '{1, 9, 2, 9};
  int a_rd_tb;

  initial begin
    reset     = 1'b1;
    clear_req = 1'b0;
    a_valid   = 1'b0;
    a_rd      = '0;
    a_data    = '0;
    b_valid   = 1'b0;
    b_rd      = '0;
    b_data    = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check_sweep("init");

    // Lone A request.
    next_cycle();
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    @(negedge clock);
    check_eq("a_only_ready", 32'(a_ready), 32'd1);
    next_cycle();
    a_valid = 1'b0;
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h1234;
    @(negedge clock);
    check_eq("a_only_we", 32'(writereg), 32'd1);
    check_eq("a_only_rd", 32'(rd), 32'd5);
    check_eq("a_only_wd", writedata, 32'hDEADBEEF);
    // prio now B: A would lose against B, B is ready.
    check_eq("prio_b_a_ready", 32'(a_ready), 32'd0);
    check_eq("b_x0_ready", 32'(b_ready), 32'd1);
    next_cycle();
    b_valid = 1'b0;
    @(negedge clock);
    check_eq("b_x0_we", 32'(writereg), 32'd0);
    check_eq("b_x0_rd", 32'(rd), 32'd0);
    check_eq("b_x0_wd", writedata, 32'h1234);

    // Both valid: grants alternate A, B, A, B.
    a_rd_tb = 1;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      a_valid = 1'b1; a_rd = 5'(a_rd_tb); a_data = 32'h100 + 32'(a_rd_tb);
      b_valid = 1'b1; b_rd = 5'd9;        b_data = 32'hB0B00009;
      @(negedge clock);
      check_eq($sformatf("rr_a_ready%0d", k), 32'(a_ready), 32'((k % 2) == 0));
      check_eq($sformatf("rr_b_ready%0d", k), 32'(b_ready), 32'((k % 2) == 1));
      if (k > 0) begin
        check_eq($sformatf("rr_we%0d", k - 1), 32'(writereg), 32'd1);
        check_eq($sformatf("rr_rd%0d", k - 1), 32'(rd), 32'(exp_rd[k-1]));
      end
      if ((k % 2) == 0) a_rd_tb++;
    end
    next_cycle();
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clock);
    check_eq("rr_we3", 32'(writereg), 32'd1);
    check_eq("rr_rd3", 32'(rd), 32'(exp_rd[3]));
    check_eq("rr_wd3", writedata, 32'hB0B00009);

    // Clear request wins over a simultaneous A request (cycle N).
    next_cycle();
    clear_req = 1'b1;
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h77;
    @(negedge clock);
    check_eq("clr_a_ready", 32'(a_ready), 32'd0);
    check_eq("clr_b_ready", 32'(b_ready), 32'd0);
    next_cycle();
    clear_req = 1'b0;
    @(negedge clock);
    check_eq("clr_we_n1", 32'(writereg), 32'd0);
    check_eq("clr_busy_n1", 32'(busy), 32'd1);
    check_eq("clr_a_ready_n1", 32'(a_ready), 32'd0);
    for (int j = 2; j <= 33; j++) begin
      next_cycle();
      @(negedge clock);
      check_eq($sformatf("clr_we_n%0d", j), 32'(writereg), 32'd1);
      check_eq($sformatf("clr_rd_n%0d", j), 32'(rd), 32'(j - 2));
      check_eq($sformatf("clr_wd_n%0d", j), writedata, 32'd0);
      check_eq($sformatf("clr_busy_n%0d", j), 32'(busy), 32'(j <= 32));
      check_eq($sformatf("clr_a_ready_n%0d", j), 32'(a_ready), 32'(j == 33));
    end
    next_cycle();
    a_valid = 1'b0;
    @(negedge clock);
    check_eq("post_clr_we", 32'(writereg), 32'd1);
    check_eq("post_clr_rd", 32'(rd), 32'd7);
    check_eq("post_clr_wd", writedata, 32'h77);

    // Reset pulsed while the sweep is at index 10.
    next_cycle();
    clear_req = 1'b1;
    next_cycle();
    clear_req = 1'b0;
    repeat (10) next_cycle();
    @(negedge clock);
    check_eq("mid_sweep_rd", 32'(rd), 32'd9);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    check_sweep("rst");

    // Reset in RUN drops a write granted in the same cycle.
    next_cycle();
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h33;
    reset = 1'b1;
    @(negedge clock);
    check_eq("rst_run_a_ready", 32'(a_ready), 32'd1);
    next_cycle();
    reset = 1'b0;
    a_valid = 1'b0;
    @(negedge clock);
    check_eq("rst_run_we", 32'(writereg), 32'd0);
    check_eq("rst_run_busy", 32'(busy), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
